riscv_lsu: RTL
==============

// Module: riscv_lsu
// PURPOSE
//  Load/store unit directly downstream of the execute-stage ALU. Takes the ALU-computed
//  effective address plus rs2 store data, performs one byte/half/word access on the data
//  memory over a req/gnt + rvalid bus, and returns sign/zero-extended load data to writeback.
//  Stalls the pipeline while an access is outstanding. Flags misaligned accesses instead of issuing them.
// PARAMETERS
//  WORD_LENGTH  32  datapath/address width; only 32 is supported (4 byte lanes)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  ex_valid      in   1   EX stage presents an instruction this cycle
//  ex_ren        in   1   instruction is a load
//  ex_wen        in   1   instruction is a store
//  ex_funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
//  ex_addr       in   W   effective address (ALU result)
//  ex_wdata      in   W   store data (rs2)
//  lsu_busy      out  1   stall request to pipeline (combinational)
//  lsu_done      out  1   1-cycle pulse: access complete
//  lsu_rdata     out  W   extended load data; valid while lsu_done, held until next load completes
//  lsu_misalign  out  1   1-cycle pulse: misaligned access rejected
//  dmem_req      out  1   bus request
//  dmem_gnt      in   1   bus accepts request this cycle
//  dmem_we       out  1   1 = write
//  dmem_addr     out  W   word address {addr[W-1:2],2'b00}
//  dmem_wdata    out  W   lane-replicated store data
//  dmem_be       out  4   byte enables
//  dmem_rvalid   in   1   read data valid (loads only, >=1 cycle after gnt)
//  dmem_rdata    in   W   read word
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 incl. lsu_rdata. Async: dmem_req/lsu_busy drop immediately
//    mid-operation; outstanding access abandoned, late rvalid ignored.
//  - mem_op = ex_valid & (ex_ren | ex_wen); ren&wen both set -> load.
//  - lsu_busy = (state!=IDLE) | (state==IDLE & mem_op & aligned & !lsu_done).
//  - FSM IDLE -> REQ -> [RESP] -> IDLE.
//    IDLE: if mem_op & !lsu_done: aligned -> register addr/we/wdata/be/funct3, go REQ;
//      misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> lsu_misalign=1 next cycle, no bus access, stay IDLE.
//      lsu_done high blocks re-acceptance of the same held instruction.
//    REQ: dmem_req=1; addr/we/wdata/be held stable until dmem_gnt. On gnt: store -> IDLE with
//      lsu_done=1 next cycle; load -> RESP.
//    RESP: wait dmem_rvalid; on it register extended data into lsu_rdata, lsu_done=1 next cycle, go IDLE.
//  - dmem_rvalid outside RESP (incl. same cycle as gnt) ignored.
//  - Lanes: B be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; H be=addr[1]?1100:0011,
//    wdata={2{wdata[15:0]}}; W be=1111. Loads drive the same be.
//  - Load extract: byte at rdata[8*addr[1:0]+:8], half at rdata[16*addr[1]+:16];
//    B/H sign-extend, BU/HU zero-extend, W passthrough.
//  - Latency (gnt and rvalid at earliest): accept edge T0; store done in T2, load done in T3.
//  - Exactly one lsu_done per accepted access; lsu_done and lsu_misalign never both high.
//  - Store completion leaves lsu_rdata unchanged.
// TESTING
//  1 SW addr 0x104 data 0xDEADBEEF, gnt at once -> dmem_addr 0x104, be 1111, wdata DEADBEEF, we=1; done T2.
//  2 LB addr 0x103, rdata 0x80FF7F01 -> lsu_rdata 0xFFFFFF80; LBU same -> 0x00000080; done T3.
//  3 LH addr 0x102, rdata 0x80011234 -> 0xFFFF8001; SH addr 0x102 data 0xABCD -> wdata ABCDABCD, be 1100.
//  4 LW addr 0x101 -> lsu_misalign pulse 1 cycle, no dmem_req, lsu_busy 0, no lsu_done.
//  5 gnt low 3 cycles, rvalid 2 cycles late -> req/addr/wdata/be stable, busy held, single done.
//  6 rst_n low in RESP -> req/busy/done 0 at once; stray rvalid in IDLE ignored; next LW completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between the EX stage and the data memory bus.
// Accepts one aligned byte/half/word access, stalls the pipeline until it completes, rejects misaligned ones.
module riscv_lsu #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic                   ex_ren,
    input  logic                   ex_wen,
    input  logic [2:0]             ex_funct3,
    input  logic [WORD_LENGTH-1:0] ex_addr,
    input  logic [WORD_LENGTH-1:0] ex_wdata,
    output logic                   lsu_busy,
    output logic                   lsu_done,
    output logic [WORD_LENGTH-1:0] lsu_rdata,
    output logic                   lsu_misalign,
    output logic                   dmem_req,
    input  logic                   dmem_gnt,
    output logic                   dmem_we,
    output logic [WORD_LENGTH-1:0] dmem_addr,
    output logic [WORD_LENGTH-1:0] dmem_wdata,
    output logic [3:0]             dmem_be,
    input  logic                   dmem_rvalid,
    input  logic [WORD_LENGTH-1:0] dmem_rdata
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] addr_q, addr_d;
    logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
    logic [WORD_LENGTH-1:0] rdata_q, rdata_d;
    logic [3:0]             be_q, be_d;
    logic [2:0]             funct3_q, funct3_d;
    logic                   we_q, we_d;
    logic                   done_q, done_d;
    logic                   misalign_q, misalign_d;

    logic                   mem_op;
    logic                   is_half;
    logic                   is_word;
    logic                   aligned;
    logic [3:0]             be_new;
    logic [WORD_LENGTH-1:0] wdata_new;
    logic [WORD_LENGTH-1:0] load_ext;
    logic [7:0]             rd_byte [4];
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;

    assign mem_op  = ex_valid & (ex_ren | ex_wen);
    // Unlisted funct3 encodings fall into the word class.
    assign is_half = (ex_funct3 == 3'b001) || (ex_funct3 == 3'b101);
    assign is_word = !is_half && (ex_funct3 != 3'b000) && (ex_funct3 != 3'b100);
    assign aligned = is_word ? (ex_addr[1:0] == 2'b00) : (is_half ? !ex_addr[0] : 1'b1);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = ex_wdata;
        if (is_half) begin
            be_new    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{ex_wdata[15:0]}};
        end else if (!is_word) begin
            be_new    = 4'b0001 << ex_addr[1:0];
            wdata_new = {4{ex_wdata[7:0]}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_byte[addr_q[1:0]];
    assign half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{(WORD_LENGTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {{(WORD_LENGTH-8){1'b0}}, byte_sel};
            3'b001:  load_ext = {{(WORD_LENGTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_ext = {{(WORD_LENGTH-16){1'b0}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q still high means the completed instruction is being held for one more edge.
                if (mem_op && !done_q) begin
                    if (aligned) begin
                        addr_d   = ex_addr;
                        wdata_d  = wdata_new;
                        be_d     = be_new;
                        funct3_d = ex_funct3;
                        we_d     = !ex_ren;
                        state_d  = REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    rdata_d = load_ext;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    assign lsu_busy     = (state_q != IDLE) || (mem_op && aligned && !done_q);
    assign lsu_done     = done_q;
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = misalign_q;
    assign dmem_req     = (state_q == REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[WORD_LENGTH-1:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;

endmodule
